pc_fetch_ctrl: RTL and testbench

Parametrised program-counter and fetch-control unit for the pipelined core, replacing the plain PC register at the IF stage. It holds the fetch address and arbitrates, cycle by cycle, between:
- sequential advance,
- branch/jump redirect from ID/EX,
- load-use hazard hold,
- memory/cache freeze.

It adds a start-up FSM, a one-entry pending-redirect buffer so redirects arriving during a cache freeze are not lost, misalignment detection, and a fetch counter.

---
 rtl/pc_fetch_pkg.sv | 25 ++
 rtl/pc_redirect_buf.sv | 36 +++
 rtl/pc_fetch_ctrl.sv | 113 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared types and helpers for the IF-stage program counter.
// Holds the fetch FSM state type and the alignment helpers.
package pc_fetch_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

   // floor(log2(n)); n is a power of two here, so this is exact
   function automatic int log2_int(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 30; i++) begin
         if ((1 << (i + 1)) <= n) r = i + 1;
      end
      return r;
   endfunction

   // Mask of the PC bits that must be zero in an aligned fetch address
   function automatic logic [63:0] align_mask(input int bytes);
      return (64'd1 << log2_int(bytes)) - 64'd1;
   endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending-redirect holder; a new load overwrites the old entry.
// Ports: clk_i, rst_i (async, active-low), load_i/load_val_i, consume_i,
//        clear_i, valid_o, val_o.
module pc_redirect_buf #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         consume_i,
   input  logic         clear_i,
   output logic         valid_o,
   output logic [W-1:0] val_o
);

   logic         valid_q;
   logic [W-1:0] val_q;

   // Load beats consume/clear so a capture is never dropped
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= 1'b0;
         val_q   <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         val_q   <= load_val_i;
      end else if (consume_i || clear_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign val_o   = val_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch control for the IF stage.
// Ports: clk_i, rst_i (async, active-low), start_i, hazard_stall_i,
//        mem_stall_i, redirect_valid_i/redirect_pc_i, pc_o,
//        fetch_valid_o, pend_valid_o, misalign_o, fetch_cnt_o.
module pc_fetch_ctrl
   import pc_fetch_pkg::*;
#(
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
   parameter int                INSTR_BYTES = 4,
   parameter int                CNT_W       = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              hazard_stall_i,
   input  logic              mem_stall_i,
   input  logic              redirect_valid_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              fetch_valid_o,
   output logic              pend_valid_o,
   output logic              misalign_o,
   output logic [CNT_W-1:0]  fetch_cnt_o
);

   localparam logic [ADDR_W-1:0] LOW_M =
      ADDR_W'(align_mask(INSTR_BYTES));
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_BYTES);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              mis_q, mis_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              buf_load, buf_consume, buf_clear;
   logic              pend_v;
   logic [ADDR_W-1:0] pend_pc;
   logic [ADDR_W-1:0] rd_al;
   logic              rd_mis;

   assign rd_al  = redirect_pc_i & ~LOW_M;
   assign rd_mis = |(redirect_pc_i & LOW_M);

   assign fetch_valid_o = (state_q == RUN) & ~mem_stall_i
                          & ~hazard_stall_i;

   pc_redirect_buf #(.W(ADDR_W)) u_buf (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (buf_load),
      .load_val_i (rd_al),
      .consume_i  (buf_consume),
      .clear_i    (buf_clear),
      .valid_o    (pend_v),
      .val_o      (pend_pc)
   );

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      buf_load    = 1'b0;
      buf_consume = 1'b0;
      buf_clear   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) state_d = RUN;
            buf_load = redirect_valid_i;
         end
         RUN: begin
            if (!start_i) state_d = IDLE;
            // A redirect flushes, so it outranks the load-use hold
            if (mem_stall_i) begin
               buf_load = redirect_valid_i;
            end else if (redirect_valid_i) begin
               pc_d      = rd_al;
               buf_clear = 1'b1;
            end else if (pend_v) begin
               pc_d        = pend_pc;
               buf_consume = 1'b1;
            end else if (!hazard_stall_i) begin
               pc_d = pc_q + STEP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Every redirect is either applied or buffered, so flag on arrival
   assign mis_d = mis_q | (redirect_valid_i & rd_mis);
   assign cnt_d = (fetch_valid_o && (cnt_q != '1))
                  ? cnt_q + CNT_W'(1) : cnt_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         pc_q    <= RESET_VEC;
         mis_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         mis_q   <= mis_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc_o         = pc_q;
   assign pend_valid_o = pend_v;
   assign misalign_o   = mis_q;
   assign fetch_cnt_o  = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: 32-bit main instance plus an
// 8-bit instance for PC wrap-around.
module tb_pc_fetch_ctrl;

   logic        clk;
   logic        rst_i;
   logic        start, hz, ms, rv;
   logic [31:0] rpc;
   logic        start8;

   logic [31:0] pc;
   logic        fv, pend, mis;
   logic [31:0] cnt;
   logic [7:0]  pc8;
   logic        fv8, pend8, mis8;
   logic [7:0]  cnt8;

   typedef struct packed {
      logic [31:0] pc;
      logic        fv;
      logic        pend;
      logic        mis;
      logic [31:0] cnt;
      logic [7:0]  pc8;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   pc_fetch_ctrl dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .start_i          (start),
      .hazard_stall_i   (hz),
      .mem_stall_i      (ms),
      .redirect_valid_i (rv),
      .redirect_pc_i    (rpc),
      .pc_o             (pc),
      .fetch_valid_o    (fv),
      .pend_valid_o     (pend),
      .misalign_o       (mis),
      .fetch_cnt_o      (cnt)
   );

   pc_fetch_ctrl #(
      .ADDR_W    (8),
      .RESET_VEC (8'hF8),
      .CNT_W     (8)
   ) dut8 (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .start_i          (start8),
      .hazard_stall_i   (1'b0),
      .mem_stall_i      (1'b0),
      .redirect_valid_i (1'b0),
      .redirect_pc_i    (8'h00),
      .pc_o             (pc8),
      .fetch_valid_o    (fv8),
      .pend_valid_o     (pend8),
      .misalign_o       (mis8),
      .fetch_cnt_o      (cnt8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int n,
                      input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s rec%0d: got %h expected %h", nm, n, act, req);
      end
   endtask

   // Monitor: samples just after each negedge, once inputs have settled
   initial begin : monitor
      int   n;
      exp_t e;
      n = 0;
      forever begin
         @(negedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc",      n, pc,                 e.pc);
            chk("fvalid",  n, {31'd0, fv},        {31'd0, e.fv});
            chk("pend",    n, {31'd0, pend},      {31'd0, e.pend});
            chk("misalgn", n, {31'd0, mis},       {31'd0, e.mis});
            chk("cnt",     n, cnt,                e.cnt);
            chk("pc8",     n, {24'd0, pc8},       {24'd0, e.pc8});
            n++;
         end
      end
   end

   task automatic drv(input logic st, input logic h, input logic m,
                      input logic r, input logic [31:0] a);
      @(negedge clk);
      start = st;
      hz    = h;
      ms    = m;
      rv    = r;
      rpc   = a;
   endtask

   task automatic ex(input logic [31:0] p, input logic f,
                     input logic pv, input logic mi,
                     input logic [31:0] c, input logic [7:0] p8);
      exp_t e;
      e.pc   = p;
      e.fv   = f;
      e.pend = pv;
      e.mis  = mi;
      e.cnt  = c;
      e.pc8  = p8;
      q.push_back(e);
   endtask

   initial begin : stim
      rst_i  = 1'b0;
      start  = 1'b0;
      hz     = 1'b0;
      ms     = 1'b0;
      rv     = 1'b0;
      rpc    = '0;
      start8 = 1'b0;

      // reset held, start already high: still no fetch
      drv(1, 0, 0, 0, 0);          ex(32'h0,   0, 0, 0, 0,  8'hF8);
      #3 rst_i = 1'b1;
      // sequential run
      drv(1, 0, 0, 0, 0);          ex(32'h0,   1, 0, 0, 0,  8'hF8);
      drv(1, 0, 0, 0, 0);          ex(32'h4,   1, 0, 0, 1,  8'hF8);
      drv(1, 0, 0, 0, 0);          ex(32'h8,   1, 0, 0, 2,  8'hF8);
      drv(1, 0, 0, 0, 0);          ex(32'hC,   1, 0, 0, 3,  8'hF8);
      // load-use hold
      drv(1, 1, 0, 0, 0);          ex(32'h10,  0, 0, 0, 4,  8'hF8);
      drv(1, 1, 0, 0, 0);          ex(32'h10,  0, 0, 0, 4,  8'hF8);
      drv(1, 0, 0, 0, 0);          ex(32'h10,  1, 0, 0, 4,  8'hF8);
      drv(1, 0, 0, 0, 0);          ex(32'h14,  1, 0, 0, 5,  8'hF8);
      drv(1, 0, 0, 0, 0);          ex(32'h18,  1, 0, 0, 6,  8'hF8);
      drv(1, 0, 0, 0, 0);          ex(32'h1C,  1, 0, 0, 7,  8'hF8);
      // freeze with two redirects: latest wins
      drv(1, 0, 1, 0, 0);          ex(32'h20,  0, 0, 0, 8,  8'hF8);
      drv(1, 0, 1, 1, 32'h100);    ex(32'h20,  0, 0, 0, 8,  8'hF8);
      drv(1, 0, 1, 1, 32'h200);    ex(32'h20,  0, 1, 0, 8,  8'hF8);
      drv(1, 0, 0, 0, 0);          ex(32'h20,  1, 1, 0, 8,  8'hF8);
      drv(1, 0, 0, 0, 0);          ex(32'h200, 1, 0, 0, 9,  8'hF8);
      // buffered entry superseded by a fresh redirect
      drv(1, 0, 1, 1, 32'h300);    ex(32'h204, 0, 0, 0, 10, 8'hF8);
      drv(1, 0, 0, 1, 32'h400);    ex(32'h204, 1, 1, 0, 10, 8'hF8);
      drv(1, 1, 0, 0, 0);          ex(32'h400, 0, 0, 0, 11, 8'hF8);
      // misaligned redirect, then aligned redirect under hazard
      drv(1, 0, 0, 1, 32'h106);    ex(32'h400, 1, 0, 0, 11, 8'hF8);
      drv(1, 1, 0, 1, 32'h80);     ex(32'h104, 0, 0, 1, 12, 8'hF8);
      drv(1, 0, 0, 0, 0);          ex(32'h80,  1, 0, 1, 12, 8'hF8);
      // stop during freeze, buffer in IDLE, restart
      drv(0, 0, 1, 1, 32'h52);     ex(32'h84,  0, 0, 1, 13, 8'hF8);
      drv(0, 0, 0, 1, 32'h60);     ex(32'h84,  0, 1, 1, 13, 8'hF8);
      drv(1, 0, 0, 0, 0);          ex(32'h84,  0, 1, 1, 13, 8'hF8);
      drv(1, 1, 0, 0, 0);          ex(32'h84,  0, 1, 1, 13, 8'hF8);
      drv(1, 0, 0, 0, 0);          ex(32'h60,  1, 0, 1, 13, 8'hF8);
      start8 = 1'b1;
      // 8-bit instance wraps FC -> 00
      drv(1, 0, 0, 0, 0);          ex(32'h64,  1, 0, 1, 14, 8'hF8);
      drv(1, 0, 0, 0, 0);          ex(32'h68,  1, 0, 1, 15, 8'hFC);
      drv(1, 0, 1, 1, 32'h500);    ex(32'h6C,  0, 0, 1, 16, 8'h00);
      start8 = 1'b0;
      drv(1, 0, 1, 0, 0);          ex(32'h6C,  0, 1, 1, 16, 8'h04);
      // asynchronous reset mid-freeze with a pending redirect
      drv(1, 0, 1, 0, 0);
      rst_i = 1'b0;                ex(32'h0,   0, 0, 0, 0,  8'hF8);
      drv(1, 0, 0, 0, 0);          ex(32'h0,   0, 0, 0, 0,  8'hF8);
      #3 rst_i = 1'b1;
      drv(1, 0, 0, 0, 0);          ex(32'h0,   1, 0, 0, 0,  8'hF8);
      drv(1, 0, 0, 0, 0);          ex(32'h4,   1, 0, 0, 1,  8'hF8);

      @(negedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d records left, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
